fetch_unit: RTL and testbench

Instruction fetch stage for the RISC-V core. Owns the program counter, issues word reads to instruction memory over a valid/ready request port with variable-latency responses, and holds each fetched instruction with its PC until decode accepts it. Decode and the immediate extender consume `instr`. Branch and jump targets computed downstream return through the redirect port.

---
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Bundles the instruction-memory request/response channel and the decode/redirect
// handshakes of the fetch stage; master is the fetch side, slave is memory/decode.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc_f;
  logic [31:0] pcplus4_f;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr, pc_f, pcplus4_f, misalign,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr, pc_f, pcplus4_f, misalign,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one word read in flight, and holds the
// fetched instruction with its PC until decode takes it. Redirects override everything.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic         clk,
  input logic         reset,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] pc_inflight, pc_inflight_nx;
  logic [31:0] instr_q, instr_nx;
  logic [31:0] pc_f_q, pc_f_nx;
  logic        drop, drop_nx;
  logic        instr_valid_q, instr_valid_nx;
  logic        misalign_q, misalign_nx;
  logic        req_fire;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

  // A redirect cycle never issues a request, so the old PC cannot leak out.
  assign bus.imem_req_valid = (state == REQ) && !bus.redirect_valid && !reset;
  assign bus.imem_addr      = pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign bus.instr       = instr_q;
  assign bus.pc_f        = pc_f_q;
  assign bus.pcplus4_f   = next_word(pc_f_q);
  assign bus.instr_valid = instr_valid_q;
  assign bus.misalign    = misalign_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= REQ;
      pc            <= RESET_PC;
      pc_inflight   <= RESET_PC;
      drop          <= 1'b0;
      instr_q       <= 32'd0;
      pc_f_q        <= 32'd0;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state         <= state_nx;
      pc            <= pc_nx;
      pc_inflight   <= pc_inflight_nx;
      drop          <= drop_nx;
      instr_q       <= instr_nx;
      pc_f_q        <= pc_f_nx;
      instr_valid_q <= instr_valid_nx;
      misalign_q    <= misalign_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    pc_nx          = pc;
    pc_inflight_nx = pc_inflight;
    drop_nx        = drop;
    instr_nx       = instr_q;
    pc_f_nx        = pc_f_q;
    instr_valid_nx = instr_valid_q;
    misalign_nx    = 1'b0;

    if (bus.redirect_valid) begin
      pc_nx       = align_word(bus.redirect_pc);
      misalign_nx = |bus.redirect_pc[1:0];
      case (state)
        REQ: state_nx = REQ;
        WAIT: begin
          // A response landing with the redirect is stale; nothing left to drain.
          if (bus.imem_rsp_valid) begin
            state_nx = REQ;
            drop_nx  = 1'b0;
          end else begin
            drop_nx  = 1'b1;
          end
        end
        HOLD: begin
          instr_valid_nx = 1'b0;
          state_nx       = REQ;
        end
        default: state_nx = REQ;
      endcase
    end else begin
      case (state)
        REQ: begin
          if (req_fire) begin
            pc_inflight_nx = pc;
            state_nx       = WAIT;
          end
        end
        WAIT: begin
          if (bus.imem_rsp_valid) begin
            if (drop) begin
              drop_nx  = 1'b0;
              state_nx = REQ;
            end else begin
              instr_nx       = bus.imem_rsp_data;
              pc_f_nx        = pc_inflight;
              pc_nx          = next_word(pc_inflight);
              instr_valid_nx = 1'b1;
              state_nx       = HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.instr_ready) begin
            instr_valid_nx = 1'b0;
            state_nx       = REQ;
          end
        end
        default: state_nx = REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a memory responder, a redirect/decode driver and a
// scoreboard predicting the delivered instruction stream from redirect epochs.
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic clk = 1'b0;
  logic reset;
  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RPC)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_seen  = 0;

  // memory responder and stimulus knobs
  logic        busy = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  int          cnt = 0;
  logic        acc_last = 1'b0;
  int unsigned lat_min = 1, lat_max = 1;
  int unsigned rdy_pct = 100, ird_pct = 100, redir_pct = 0;
  logic        force_redir = 1'b0;
  logic [31:0] force_pc = 32'd0;

  // scoreboard state
  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_pc = RPC;
  int          epoch = 0, req_epoch = 0;
  logic        outstanding = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic        prev_valid = 1'b0, kill_next = 1'b0, exp_mis = 1'b0;
  logic [31:0] held_instr = 32'd0, held_pc = 32'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: observe the handshake before the edge, update memory and drive after it.
  task automatic step();
    logic        acc_s, rsp_s;
    logic [31:0] addr_s;
    @(negedge clk);
    acc_s  = bus.imem_req_valid && bus.imem_req_ready;
    rsp_s  = bus.imem_rsp_valid;
    addr_s = bus.imem_addr;
    @(posedge clk);
    #1;
    acc_last = acc_s;
    if (rsp_s) busy = 1'b0;
    if (acc_s) begin
      busy     = 1'b1;
      mem_addr = addr_s;
      cnt      = int'($urandom_range(lat_max, lat_min));
    end
    if (busy) begin
      cnt--;
      bus.imem_rsp_valid = (cnt == 0);
    end else begin
      bus.imem_rsp_valid = 1'b0;
    end
    bus.imem_rsp_data  = bus.imem_rsp_valid ? mem_word(mem_addr) : $urandom();
    bus.imem_req_ready = !busy && ($urandom_range(99) < rdy_pct);
    bus.instr_ready    = $urandom_range(99) < ird_pct;
    bus.redirect_valid = force_redir || ($urandom_range(99) < redir_pct);
    bus.redirect_pc    = force_redir ? force_pc : $urandom();
    force_redir = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"},   32'(bus.imem_req_valid), 32'd0);
    check({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'd0);
    check({tag, "_instr"},       bus.instr, 32'd0);
    check({tag, "_pc_f"},        bus.pc_f, 32'd0);
    check({tag, "_pcplus4"},     bus.pcplus4_f, 32'd4);
    check({tag, "_misalign"},    32'(bus.misalign), 32'd0);
  endtask

  // Monitor: reference model advanced once per cycle, compared against DUT outputs.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_pc      = RPC;
        outstanding = 1'b0;
        exp_instr_q.delete();
        exp_pc_q.delete();
        prev_valid  = 1'b0;
        kill_next   = 1'b0;
        exp_mis     = 1'b0;
      end else begin
        if (kill_next) check("valid_falls", 32'(bus.instr_valid), 32'd0);
        if (bus.instr_valid) begin
          if (!prev_valid) begin
            n_tests++;
            if (exp_instr_q.size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_instr: got pc_f %h instr %h expected none", bus.pc_f, bus.instr);
            end else begin
              held_instr = exp_instr_q.pop_front();
              held_pc    = exp_pc_q.pop_front();
              n_seen++;
              check("instr", bus.instr, held_instr);
              check("pc_f", bus.pc_f, held_pc);
              check("pcplus4_f", bus.pcplus4_f, held_pc + 32'd4);
            end
          end else begin
            check("hold_instr", bus.instr, held_instr);
            check("hold_pc_f", bus.pc_f, held_pc);
          end
          check("no_req_in_hold", 32'(bus.imem_req_valid), 32'd0);
        end
        check("misalign", 32'(bus.misalign), 32'(exp_mis));

        exp_mis   = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
        kill_next = bus.redirect_valid || (bus.instr_valid && bus.instr_ready);
        prev_valid = bus.instr_valid;
        if (bus.redirect_valid) begin
          epoch++;
          exp_pc = bus.redirect_pc & 32'hFFFF_FFFC;
          check("no_req_on_redirect", 32'(bus.imem_req_valid), 32'd0);
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          check("imem_addr", bus.imem_addr, exp_pc);
          check("one_outstanding", 32'(outstanding), 32'd0);
          outstanding = 1'b1;
          req_epoch   = epoch;
          req_addr    = bus.imem_addr;
        end else if (bus.imem_rsp_valid && outstanding) begin
          // Delivered only if no redirect happened since the request left.
          if (req_epoch == epoch) begin
            exp_instr_q.push_back(bus.imem_rsp_data);
            exp_pc_q.push_back(req_addr);
            exp_pc = req_addr + 32'd4;
          end
          outstanding = 1'b0;
        end
      end
    end
  end

  initial begin
    logic found;
    reset = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'd0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    bus.imem_req_ready = 1'b1;
    reset = 1'b0;

    // Back-to-back fetch from RESET_PC with single-cycle memory.
    repeat (15) step();

    // Decode backpressure, then a misaligned redirect in HOLD with ready high.
    ird_pct = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = bus.instr_valid;
    end
    check("hold_reached", 32'(found), 32'd1);
    repeat (5) step();
    ird_pct     = 100;
    force_redir = 1'b1;
    force_pc    = 32'h0000_0402;
    repeat (1) step();
    ird_pct = 0;
    force_redir = 1'b0;
    repeat (1) step();
    ird_pct = 100;
    repeat (10) step();

    // Random mix: variable latency, backpressure, redirects while waiting/holding.
    lat_min = 1; lat_max = 4;
    rdy_pct = 70; ird_pct = 60; redir_pct = 8;
    repeat (1500) step();

    // Wrap at the top of the address space.
    redir_pct = 0; rdy_pct = 100; ird_pct = 100; lat_max = 1;
    repeat (6) step();
    force_redir = 1'b1;
    force_pc    = 32'hFFFF_FFFC;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus.instr_valid && bus.pc_f == 32'hFFFF_FFFC) begin
        found = 1'b1;
        check("wrap_pcplus4", bus.pcplus4_f, 32'd0);
      end
    end
    check("wrap_seen", 32'(found), 32'd1);

    // Asynchronous reset while a slow response is outstanding.
    lat_min = 4; lat_max = 4;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = acc_last;
    end
    check("wait_reached", 32'(found), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    step();
    reset = 1'b0;
    lat_min = 1; lat_max = 3;
    repeat (30) step();

    // Drain: stop issuing, let everything in flight reach decode.
    rdy_pct = 0;
    repeat (12) step();
    check("queue_drained", 32'(exp_instr_q.size()), 32'd0);
    check("progress", 32'(n_seen >= 100), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
